// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/LSU request ports and shared memory port of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      if_req_i;
  logic [ADDR_WIDTH-1:0]     if_addr_i;
  logic [DATA_WIDTH-1:0]     if_rdata_o;
  logic                      if_ack_o;

  logic                      ls_req_i;
  logic                      ls_we_i;
  logic [DATA_WIDTH/8-1:0]   ls_be_i;
  logic [ADDR_WIDTH-1:0]     ls_addr_i;
  logic [DATA_WIDTH-1:0]     ls_wdata_i;
  logic [DATA_WIDTH-1:0]     ls_rdata_o;
  logic                      ls_ack_o;

  logic                      mem_en_o;
  logic [DATA_WIDTH/8-1:0]   mem_we_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;

  logic                      busy_o;

  // The arbiter side: answers both requesters and drives the memory
  modport master (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output ls_rdata_o, ls_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  ls_rdata_o, ls_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between instruction fetch and the LSU
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic                  grant_any, grant_ls, capture;
  logic                  last_ls;
  logic                  lat_ls, lat_we;
  logic [BE_WIDTH-1:0]   lat_be;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [2:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] if_rdata, ls_rdata;

  assign grant_any = bus.if_req_i | bus.ls_req_i;
  // On a tie the port that did not win last time gets the memory
  assign grant_ls  = bus.ls_req_i & (~bus.if_req_i | ~last_ls);
  assign capture   = (state == ST_WAIT) && (lat_cnt == 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.if_ack_o    = 1'b0;
    bus.ls_ack_o    = 1'b0;
    bus.busy_o      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (grant_any) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.mem_en_o    = 1'b1;
        bus.mem_we_o    = lat_we ? lat_be : '0;
        bus.mem_addr_o  = lat_addr;
        bus.mem_wdata_o = lat_wdata;
        state_nxt       = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.if_ack_o = ~lat_ls;
        bus.ls_ack_o = lat_ls;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ls   <= 1'b0;
      lat_ls    <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_cnt   <= 3'd0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if (state == ST_IDLE && grant_any) begin
        lat_ls    <= grant_ls;
        lat_we    <= grant_ls & bus.ls_we_i;
        lat_be    <= grant_ls ? bus.ls_be_i : '0;
        lat_addr  <= grant_ls ? bus.ls_addr_i : bus.if_addr_i;
        lat_wdata <= grant_ls ? bus.ls_wdata_i : '0;
      end
      if (state == ST_ISSUE) begin
        lat_cnt <= 3'(MEM_LATENCY);
        last_ls <= lat_ls;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (capture) begin
        if (lat_ls) ls_rdata <= bus.mem_rdata_i;
        else        if_rdata <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.if_rdata_o = if_rdata;
  assign bus.ls_rdata_o = ls_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter across several memory latencies
module tb_mem_arbiter;
  localparam int NI = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req, ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        fixed_en;
  logic [31:0] fixed_val;
  logic [31:0] mem_rdata;

  function automatic logic [31:0] pat(input int c);
    return (32'(c) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  assign mem_rdata = fixed_en ? fixed_val : pat(cyc);

  function automatic int lat_of(input logic [2:0] s);
    case (s)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 3;
      3'd3: return 4;
      default: return 7;
    endcase
  endfunction

  logic        if_ack_a [NI];
  logic        ls_ack_a [NI];
  logic        busy_a   [NI];
  logic        mem_en_a [NI];
  logic [3:0]  mem_we_a [NI];
  logic [31:0] mem_addr_a [NI];
  logic [31:0] mem_wdata_a [NI];
  logic [31:0] if_rdata_a [NI];
  logic [31:0] ls_rdata_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 7;
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
    assign bus.if_req_i    = if_req;
    assign bus.if_addr_i   = if_addr;
    assign bus.ls_req_i    = ls_req;
    assign bus.ls_we_i     = ls_we;
    assign bus.ls_be_i     = ls_be;
    assign bus.ls_addr_i   = ls_addr;
    assign bus.ls_wdata_i  = ls_wdata;
    assign bus.mem_rdata_i = mem_rdata;
    assign if_ack_a[g]     = bus.if_ack_o;
    assign ls_ack_a[g]     = bus.ls_ack_o;
    assign busy_a[g]       = bus.busy_o;
    assign mem_en_a[g]     = bus.mem_en_o;
    assign mem_we_a[g]     = bus.mem_we_o;
    assign mem_addr_a[g]   = bus.mem_addr_o;
    assign mem_wdata_a[g]  = bus.mem_wdata_o;
    assign if_rdata_a[g]   = bus.if_rdata_o;
    assign ls_rdata_a[g]   = bus.ls_rdata_o;
  end

  logic [2:0]  sel;
  logic        ack_if, ack_ls, busy, mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, if_rdata, ls_rdata;

  always_comb begin
    ack_if    = if_ack_a[sel];
    ack_ls    = ls_ack_a[sel];
    busy      = busy_a[sel];
    mem_en    = mem_en_a[sel];
    mem_we    = mem_we_a[sel];
    mem_addr  = mem_addr_a[sel];
    mem_wdata = mem_wdata_a[sel];
    if_rdata  = if_rdata_a[sel];
    ls_rdata  = ls_rdata_a[sel];
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        ls;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mdl_if_rd = '0;
  logic [31:0] mdl_ls_rd = '0;
  int          n_acks = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mdl_if_rd = '0;
      mdl_ls_rd = '0;
    end else if (ack_if || ack_ls) begin
      n_acks++;
      check_eq("ack_onehot", 32'(ack_if & ack_ls), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ack", 32'({ack_ls, ack_if}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ack_port", 32'(ack_ls), 32'(mon_e.ls));
        check_eq("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.ls) begin
          check_eq("ls_rdata", ls_rdata, mon_e.data);
          check_eq("if_rdata_hold", if_rdata, mdl_if_rd);
          mdl_ls_rd = mon_e.data;
        end else begin
          check_eq("if_rdata", if_rdata, mon_e.data);
          check_eq("ls_rdata_hold", ls_rdata, mdl_ls_rd);
          mdl_if_rd = mon_e.data;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"},   32'(busy), 32'd0);
    check_eq({tag, "_if_ack"}, 32'(ack_if), 32'd0);
    check_eq({tag, "_ls_ack"}, 32'(ack_ls), 32'd0);
    check_eq({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_addr"},   mem_addr, 32'd0);
    check_eq({tag, "_wdata"},  mem_wdata, 32'd0);
    check_eq({tag, "_if_rd"},  if_rdata, 32'd0);
    check_eq({tag, "_ls_rd"},  ls_rdata, 32'd0);
  endtask

  task automatic do_reset(input logic [2:0] s);
    #2 reset = 1'b1;
    sel    = s;
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic access(input logic ls, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic scramble);
    int   t, n, lat;
    exp_t e;
    lat = lat_of(sel);
    @(posedge clk); #1;
    t = cyc;
    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    e.ls   = ls;
    e.cyc  = t + 2 + lat;
    e.data = fixed_en ? fixed_val : pat(t + 1 + lat);
    exp_q.push_back(e);
    check_eq("sample_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq("issue_en", 32'(mem_en), 32'd1);
    check_eq("issue_we", 32'(mem_we), (ls && we) ? 32'(be) : 32'd0);
    check_eq("issue_addr", mem_addr, addr);
    if (ls) check_eq("issue_wdata", mem_wdata, wdata);
    check_eq("issue_busy", 32'(busy), 32'd1);
    if (scramble) begin
      @(posedge clk); #1;
      ls_addr = ~addr; ls_wdata = ~wdata; ls_we = ~we; ls_be = ~be; if_addr = ~addr;
      ls_req = 1'b0; if_req = 1'b0;
      check_eq("wait_en", 32'(mem_en), 32'd0);
      check_eq("wait_we", 32'(mem_we), 32'd0);
      check_eq("wait_addr", mem_addr, 32'd0);
      check_eq("wait_wdata", mem_wdata, 32'd0);
      check_eq("wait_busy", 32'(busy), 32'd1);
    end
    n = 0;
    while (!(ack_if || ack_ls) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ack_seen", 32'(ack_if || ack_ls), 32'd1);
    if_req = 1'b0;
    ls_req = 1'b0;
    @(posedge clk); #1;
    check_eq("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic tie3();
    int   t, n, got, lat;
    exp_t e;
    lat = lat_of(sel);
    @(posedge clk); #1;
    t = cyc;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0000_0300; ls_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      e.ls   = (k != 1);
      e.cyc  = t + k * (lat + 3) + 2 + lat;
      e.data = pat(t + k * (lat + 3) + 1 + lat);
      exp_q.push_back(e);
    end
    n = 0;
    got = 0;
    while (got < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (ack_if || ack_ls) got++;
    end
    check_eq("tie_acks", 32'(got), 32'd3);
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("tie_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_test();
    int acks_before;
    access(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, 1'b0);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    acks_before = n_acks;
    reset = 1'b1;
    #1;
    check_zero("rst_wait");
    if_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_next", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("rst_no_ack", 32'(n_acks), 32'(acks_before));
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h0000_0080; ls_wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    check_eq("pre_rst_issue_en", 32'(mem_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_zero("rst_issue");
    ls_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("rst_issue_no_ack", 32'(n_acks), 32'(acks_before));
  endtask

  initial begin
    reset = 1'b1;
    sel = 3'd0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    fixed_en = 1'b0; fixed_val = '0;
    #1;
    check_zero("por");
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    fixed_en = 1'b1;
    fixed_val = 32'h0051_0093;
    access(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
    fixed_en = 1'b0;

    do_reset(3'd1);
    access(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b0);

    do_reset(3'd0);
    tie3();

    do_reset(3'd3);
    access(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'h1234_5678, 1'b1);
    access(1'b0, 1'b0, 4'h0, 32'h0000_0408, 32'h0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      do_reset((i == 0) ? 3'd0 : (i == 1) ? 3'd3 : 3'd4);
      access(1'b0, 1'b0, 4'h0, 32'h0000_1000 + 32'(i), 32'h0, 1'b0);
      access(1'b1, 1'b0, 4'hF, 32'h0000_2000 + 32'(i), 32'h0, 1'b0);
      access(1'b1, 1'b1, 4'b1100, 32'h0000_3000, 32'h0BAD_F00D ^ 32'(i), 1'b0);
      access(1'b0, 1'b0, 4'h0, 32'h0000_4000, 32'h0, 1'b0);
    end

    do_reset(3'd2);
    reset_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port unified instruction/data memory between the RISC-V core's instruction-fetch stage and its load/store unit. It sits between the core datapath and the memory inside `top`. It serialises accesses through a small FSM and latches each granted request. It returns read data and a one-cycle acknowledge to the winning requester. On a tie it alternates grants so neither port starves.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: data word width; byte-enable width is `DATA_WIDTH/8`.
- `MEM_LATENCY`, default 1: cycles from the `mem_en_o` cycle to the cycle in which `mem_rdata_i` is valid; legal range 1..7.

- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `if_req_i` input 1: fetch request, held until `if_ack_o`.
- `if_addr_i` input ADDR_WIDTH: fetch address.
- `if_rdata_o` output DATA_WIDTH: fetched word, valid while `if_ack_o`=1.
- `if_ack_o` output 1: one-cycle fetch completion pulse.
- `ls_req_i` input 1: load/store request, held until `ls_ack_o`.
- `ls_we_i` input 1: 1 = store, 0 = load.
- `ls_be_i` input DATA_WIDTH/8: store byte enables.
- `ls_addr_i` input ADDR_WIDTH: load/store address.
- `ls_wdata_i` input DATA_WIDTH: store data.
- `ls_rdata_o` output DATA_WIDTH: load data, valid while `ls_ack_o`=1.
- `ls_ack_o` output 1: one-cycle load/store completion pulse.
- `mem_en_o` output 1: memory access strobe, one cycle per access.
- `mem_we_o` output DATA_WIDTH/8: per-byte write enables.
- `mem_addr_o` output ADDR_WIDTH: memory address.
- `mem_wdata_o` output DATA_WIDTH: memory write data.
- `mem_rdata_i` input DATA_WIDTH: memory read data.
- `busy_o` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- **IDLE:** sample both requests.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not `last_grant`.
  - On a grant, latch port ID, address, `we`, `be` and `wdata`, then go to ISSUE.
  - If no request is high, stay in IDLE.
- **ISSUE:** drive `mem_en_o`=1 and the latched address and write data.
  - `mem_we_o` = latched `be` for a store; 0 for loads and fetches.
  - Load the latency counter with `MEM_LATENCY`, set `last_grant` to the granted port, go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - The counter is 3 bits wide.
  - Capture `mem_rdata_i` into the granted port's rdata register in the cycle the counter reaches 1, i.e. the cycle `ISSUE+MEM_LATENCY`. Go to DONE.
- **DONE:** pulse the granted port's ack for one cycle. No request sampling occurs in this state. Go to IDLE.
- A store also returns an ack. `ls_rdata_o` after a store holds whatever `mem_rdata_i` was in the capture cycle, and its content is unspecified.
- Request inputs are ignored from ISSUE through DONE; the latched values govern the access.
- Each `*_rdata_o` holds its last captured value until that port's next capture.
- If a request drops before its ack (a protocol violation), the access still completes and the ack is still pulsed.
- The arbiter passes addresses through unchanged and performs no alignment checks.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = fetch, so the first tie goes to the LSU.
  - All outputs = 0, including `if_rdata_o`, `ls_rdata_o`, `mem_*`, the acks and `busy_o`.
- `mem_*` outputs are 0 in every state except ISSUE.
- **Reset mid-operation:** the in-flight access is abandoned and no ack is issued. All outputs go to 0 asynchronously.
- **Latency:** a request sampled in IDLE at cycle T produces:
  - ISSUE at T+1;
  - capture at T+1+L;
  - ack at T+2+L.
- **Throughput:** the earliest next grant is sampled at T+3+L, so one access per L+3 cycles.
- With L=1: request seen in cycle 0, `mem_en_o` in cycle 1, capture in cycle 2, ack in cycle 3, IDLE in cycle 4.
- **Continuous ties:** grants alternate LSU, fetch, LSU, and so on. The `last_grant` update happens in ISSUE.
- **`busy_o`:** high from T+1 through T+2+L inclusive.

## Test plan
- **Reset:** assert `reset` asynchronously mid-WAIT with L=3. All outputs must drop to 0 at once, no ack may follow, and `busy_o` must read 0 from the next cycle.
- **Single fetch, L=1:** addr 0x0000_0010, memory returns 0x0051_0093. `mem_en_o` must be high in cycle 1 with `mem_we_o`=0. `if_ack_o` must be high only in cycle 3, with `if_rdata_o`=0x0051_0093.
- **Store, L=2:** `ls_we_i`=1, `be`=4'b0011, addr 0x100, wdata 0xDEAD_BEEF. Cycle 1 must show `mem_we_o`=4'b0011, `mem_addr_o`=0x100 and `mem_wdata_o`=0xDEAD_BEEF. `ls_ack_o` must pulse in cycle 4 and `if_ack_o` must stay 0.
- **Tie after reset:** both ports request continuously. Grant order must be LSU, fetch, LSU, with acks at cycles 3, 7 and 11 for L=1.
- **Input change during WAIT:** change `ls_addr_i` and `ls_wdata_i` after ISSUE. `mem_*` outputs and the captured data must reflect only the latched request.
- **Latency sweep:** run L=1, 4 and 7. The ack must always land exactly L+2 cycles after the sampling cycle, with `rdata` equal to the `mem_rdata_i` value present in cycle ISSUE+L.
